fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 115 +++++++++++
 tb/tb_fetch_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - brisc instruction fetch stage
// Owns the PC, issues one word fetch at a time and hands instructions to decode through a one-entry register.
module fetch_stage #(
   parameter int              XLEN     = 32,
   parameter int              ILEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = 32'h0000_1000
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_resp_valid,
   input  logic [ILEN-1:0] imem_resp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   output logic [ILEN-1:0] out_instr,
   output logic [XLEN-1:0] out_pc,
   input  logic            out_ready
);

   typedef enum logic [1:0] {
      S_REQ   = 2'd0,
      S_WAIT  = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t          state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic            out_valid_q, out_valid_d;
   logic [ILEN-1:0] out_instr_q, out_instr_d;
   logic [XLEN-1:0] out_pc_q, out_pc_d;

   logic slot_free;
   logic req_fire;

   assign slot_free = !out_valid_q || out_ready;

   // rst_n is folded in so no request is advertised while reset is held.
   assign imem_req_valid = rst_n && (state_q == S_REQ) && slot_free && !redirect_valid;
   assign imem_req_addr  = pc_q;
   assign req_fire       = imem_req_valid && imem_req_ready;

   assign out_valid = out_valid_q;
   assign out_instr = out_instr_q;
   assign out_pc    = out_pc_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      out_valid_d = out_valid_q;
      out_instr_d = out_instr_q;
      out_pc_d    = out_pc_q;

      if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end

      case (state_q)
         S_REQ: begin
            if (req_fire) begin
               pc_d    = pc_q + XLEN'(4);
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_resp_valid) begin
               out_instr_d = imem_resp_data;
               out_pc_d    = pc_q - XLEN'(4);
               out_valid_d = 1'b1;
               state_d     = S_REQ;
            end
         end
         S_DRAIN: begin
            if (imem_resp_valid) begin
               state_d = S_REQ;
            end
         end
         default: begin
            state_d = S_REQ;
         end
      endcase

      // A redirect overrides everything above, including a same-cycle response load.
      if (redirect_valid) begin
         pc_d        = redirect_pc;
         out_valid_d = 1'b0;
         out_instr_d = out_instr_q;
         out_pc_d    = out_pc_q;
         if (state_q == S_REQ || imem_resp_valid) begin
            state_d = S_REQ;
         end else begin
            state_d = S_DRAIN;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_REQ;
         pc_q        <= RESET_PC;
         out_valid_q <= 1'b0;
         out_instr_q <= '0;
         out_pc_q    <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         out_valid_q <= out_valid_d;
         out_instr_q <= out_instr_d;
         out_pc_q    <= out_pc_d;
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
// Memory tags each response as addr ^ 32'hA5A5_0000; inputs change on the falling edge.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready = 1'b1;
   logic        imem_resp_valid = 1'b0;
   logic [31:0] imem_resp_data = '0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        out_valid;
   logic [31:0] out_instr;
   logic [31:0] out_pc;
   logic        out_ready = 1'b1;

   int n_cmp = 0;
   int n_fail = 0;

   int          mem_lat = 1;
   int          lat_cnt = 0;
   logic [31:0] pend_addr = '0;

   fetch_stage dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_addr  (imem_req_addr),
      .imem_req_ready (imem_req_ready),
      .imem_resp_valid(imem_resp_valid),
      .imem_resp_data (imem_resp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_instr      (out_instr),
      .out_pc         (out_pc),
      .out_ready      (out_ready)
   );

   always #5 clk = ~clk;

   // Memory model: response shown mem_lat cycles after the handshake edge.
   always @(posedge clk) begin
      logic        hs;
      logic [31:0] a;
      hs = rst_n && imem_req_valid && imem_req_ready;
      a  = imem_req_addr;
      #1;
      imem_resp_valid = 1'b0;
      if (!rst_n) begin
         lat_cnt = 0;
      end else begin
         if (hs) begin
            pend_addr = a;
            lat_cnt   = mem_lat;
         end
         if (lat_cnt > 0) begin
            lat_cnt = lat_cnt - 1;
            if (lat_cnt == 0) begin
               imem_resp_valid = 1'b1;
               imem_resp_data  = pend_addr ^ 32'hA5A5_0000;
            end
         end
      end
   end

   task automatic do_reset();
      rst_n          = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      out_ready      = 1'b1;
      imem_req_ready = 1'b1;
      mem_lat        = 1;
      lat_cnt        = 0;
      imem_resp_valid = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL reset_out_pc: got %h want 0", out_pc); end
      n_cmp++; if (out_instr !== 32'h0) begin n_fail++; $display("FAIL reset_out_instr: got %h want 0", out_instr); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b want 0", imem_req_valid); end
      do_reset();
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL release_req_valid: got %b want 1", imem_req_valid); end
      n_cmp++; if (imem_req_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL release_req_addr: got %h want 00001000", imem_req_addr); end
   endtask

   task automatic test_sequence();
      logic [31:0] exp_pc;
      do_reset();
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         n_cmp++; if (out_valid !== ((k % 2) == 0)) begin n_fail++; $display("FAIL seq_valid cyc%0d: got %b want %b", k, out_valid, (k % 2) == 0); end
         if ((k % 2) == 0) begin
            exp_pc = 32'h0000_1000 + 32'(4 * (k / 2 - 1));
            n_cmp++; if (out_pc !== exp_pc) begin n_fail++; $display("FAIL seq_pc cyc%0d: got %h want %h", k, out_pc, exp_pc); end
            n_cmp++; if (out_instr !== (exp_pc ^ 32'hA5A5_0000)) begin n_fail++; $display("FAIL seq_instr cyc%0d: got %h want %h", k, out_instr, exp_pc ^ 32'hA5A5_0000); end
         end
      end
   endtask

   task automatic test_backpressure();
      do_reset();
      repeat (2) @(negedge clk);
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) begin
         #1;
         n_cmp++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid cyc%0d: got %b want 1", k, out_valid); end
         n_cmp++; if (out_pc !== 32'h0000_1000) begin n_fail++; $display("FAIL bp_pc cyc%0d: got %h want 00001000", k, out_pc); end
         n_cmp++; if (out_instr !== 32'hA5A5_1000) begin n_fail++; $display("FAIL bp_instr cyc%0d: got %h want a5a51000", k, out_instr); end
         n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_valid cyc%0d: got %b want 0", k, imem_req_valid); end
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_1004) begin n_fail++; $display("FAIL bp_resume_req: got %b/%h want 1/00001004", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_consumed: got %b want 0", out_valid); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_1004) begin n_fail++; $display("FAIL bp_next_out: got %b/%h want 1/00001004", out_valid, out_pc); end
      n_cmp++; if (out_instr !== 32'hA5A5_1004) begin n_fail++; $display("FAIL bp_next_instr: got %h want a5a51004", out_instr); end
   endtask

   task automatic test_req_stall();
      do_reset();
      repeat (2) @(negedge clk);
      imem_req_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_1004) begin n_fail++; $display("FAIL stall_req cyc%0d: got %b/%h want 1/00001004", k, imem_req_valid, imem_req_addr); end
         @(negedge clk);
      end
      imem_req_ready = 1'b1;
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_wait_valid: got %b want 0", out_valid); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_1004) begin n_fail++; $display("FAIL stall_out: got %b/%h want 1/00001004", out_valid, out_pc); end
      n_cmp++; if (imem_req_addr !== 32'h0000_1008) begin n_fail++; $display("FAIL stall_next_addr: got %h want 00001008", imem_req_addr); end
   endtask

   task automatic test_redirect_wait();
      do_reset();
      mem_lat = 3;
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_2000;
      @(negedge clk);
      redirect_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
         #1;
         n_cmp++; if (imem_req_valid !== 1'b0 || out_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_drain cyc%0d: got req %b out %b want 0/0", k, imem_req_valid, out_valid); end
         @(negedge clk);
      end
      mem_lat = 1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_stale_dropped: got %b want 0", out_valid); end
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_2000) begin n_fail++; $display("FAIL rdw_req: got %b/%h want 1/00002000", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdw_wait_valid: got %b want 0", out_valid); end
      @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_2000) begin n_fail++; $display("FAIL rdw_out: got %b/%h want 1/00002000", out_valid, out_pc); end
      n_cmp++; if (out_instr !== 32'hA5A5_2000) begin n_fail++; $display("FAIL rdw_instr: got %h want a5a52000", out_instr); end
   endtask

   task automatic test_redirect_resp();
      do_reset();
      repeat (2) @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_3000;
      #1;
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_gate: got %b want 0", imem_req_valid); end
      @(negedge clk);
      redirect_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_squash: got %b want 0", out_valid); end
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_3000) begin n_fail++; $display("FAIL rdr_req1: got %b/%h want 1/00003000", imem_req_valid, imem_req_addr); end
      @(negedge clk);
      redirect_valid = 1'b1;
      redirect_pc    = 32'h0000_4000;
      @(negedge clk);
      redirect_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rdr_resp_dropped: got %b want 0", out_valid); end
      #1;
      n_cmp++; if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_4000) begin n_fail++; $display("FAIL rdr_req2: got %b/%h want 1/00004000", imem_req_valid, imem_req_addr); end
      repeat (2) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_4000) begin n_fail++; $display("FAIL rdr_out: got %b/%h want 1/00004000", out_valid, out_pc); end
   endtask

   task automatic test_wrap();
      do_reset();
      redirect_valid = 1'b1;
      redirect_pc    = 32'hFFFF_FFFC;
      @(negedge clk);
      redirect_valid = 1'b0;
      #1;
      n_cmp++; if (imem_req_addr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_req_addr: got %h want fffffffc", imem_req_addr); end
      repeat (2) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_out: got %b/%h want 1/fffffffc", out_valid, out_pc); end
      n_cmp++; if (out_instr !== 32'h5A5A_FFFC) begin n_fail++; $display("FAIL wrap_instr: got %h want 5a5afffc", out_instr); end
      n_cmp++; if (imem_req_addr !== 32'h0000_0000) begin n_fail++; $display("FAIL wrap_next_addr: got %h want 00000000", imem_req_addr); end
   endtask

   task automatic test_async_reset();
      do_reset();
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      lat_cnt = 0;
      imem_resp_valid = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", out_valid); end
      n_cmp++; if (out_pc !== 32'h0) begin n_fail++; $display("FAIL areset_pc: got %h want 0", out_pc); end
      n_cmp++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL areset_req: got %b want 0", imem_req_valid); end
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      n_cmp++; if (imem_req_addr !== 32'h0000_1000) begin n_fail++; $display("FAIL areset_restart_addr: got %h want 00001000", imem_req_addr); end
      repeat (2) @(negedge clk);
      n_cmp++; if (out_valid !== 1'b1 || out_pc !== 32'h0000_1000) begin n_fail++; $display("FAIL areset_restart_out: got %b/%h want 1/00001000", out_valid, out_pc); end
   endtask

   initial begin
      test_reset();
      test_sequence();
      test_backpressure();
      test_req_stall();
      test_redirect_wait();
      test_redirect_resp();
      test_wrap();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
